// File: rtl/btb_pkg.sv
// Shared widths and default geometry for the LFU branch target buffer
// and its replacement helper.
package btb_pkg;
   localparam int unsigned PC_W           = 32;
   localparam int unsigned DEF_SETS       = 32;
   localparam int unsigned DEF_WAYS       = 4;
   localparam int unsigned DEF_TAG_W      = 16;
   localparam int unsigned DEF_IDX_LSB    = 2;
   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_AGE_PERIOD = 4096;
endpackage

// File: rtl/btb_victim_sel.sv
// Combinational victim picker: lowest-index invalid way, else the least-used
// way with ties going to the lowest index. Result is one-hot.
module btb_victim_sel #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic [WAYS-1:0]            valid,
   input  logic [WAYS-1:0][CNT_W-1:0] cnt,
   output logic [WAYS-1:0]            victim_c
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   logic [WAY_W-1:0] sel;
   logic [CNT_W-1:0] best;
   logic             found_inv;

   always_comb begin
      sel       = '0;
      best      = cnt[0];
      found_inv = 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!valid[w] && !found_inv) begin
            found_inv = 1'b1;
            sel       = WAY_W'(w);
         end
      end
      // strict compare keeps the lowest index on ties
      if (!found_inv) begin
         for (int w = 1; w < int'(WAYS); w++) begin
            if (cnt[w] < best) begin
               best = cnt[w];
               sel  = WAY_W'(w);
            end
         end
      end
      victim_c = WAYS'(1) << sel;
   end
endmodule

// File: rtl/btb_assoc_lfu.sv
// Set-associative BTB with LFU replacement and periodic counter halving.
// Registered lookup; update path reads pre-edge state so same-cycle lookups see old contents.
module btb_assoc_lfu
   import btb_pkg::*;
#(
   parameter int unsigned SETS       = DEF_SETS,
   parameter int unsigned WAYS       = DEF_WAYS,
   parameter int unsigned TAG_W      = DEF_TAG_W,
   parameter int unsigned IDX_LSB    = DEF_IDX_LSB,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned AGE_PERIOD = DEF_AGE_PERIOD
) (
   input  logic            clk,
   input  logic            start,
   input  logic            predict_valid,
   input  logic [PC_W-1:0] PC_predict,
   output logic            hit,
   output logic [PC_W-1:0] target_address_predict,
   input  logic            update,
   input  logic            update_taken,
   input  logic [PC_W-1:0] PC_update,
   input  logic [PC_W-1:0] target_address_update,
   input  logic            flush
);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned AGE_W = $clog2(AGE_PERIOD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [CNT_W-1:0] cnt;
   } entry_t;

   entry_t tbl [SETS][WAYS];

   logic [IDX_W-1:0]            pidx, uidx;
   logic [TAG_W-1:0]            ptag, utag;
   logic [WAYS-1:0]             pmatch, umatch, victim_c, uvalid;
   logic [WAYS-1:0][CNT_W-1:0]  ucnt;
   logic [PC_W-1:0]             ptarget_c;
   logic                        hit_c, uhit;
   logic [WAY_W-1:0]            uway, vway, wway;
   logic [AGE_W-1:0]            age;
   logic                        age_wrap;
   logic                        unused_pc;

   assign pidx      = PC_predict[IDX_LSB +: IDX_W];
   assign ptag      = PC_predict[IDX_LSB + IDX_W +: TAG_W];
   assign uidx      = PC_update[IDX_LSB +: IDX_W];
   assign utag      = PC_update[IDX_LSB + IDX_W +: TAG_W];
   assign age_wrap  = (age == AGE_W'(AGE_PERIOD - 1));
   assign unused_pc = ^{PC_predict, PC_update};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   // Replacement view of the update set
   always_comb begin
      uvalid = '0;
      ucnt   = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         uvalid[w] = tbl[uidx][w].valid;
         ucnt[w]   = tbl[uidx][w].cnt;
      end
   end

   btb_victim_sel #(.WAYS(WAYS), .CNT_W(CNT_W)) u_victim (
      .valid    (uvalid),
      .cnt      (ucnt),
      .victim_c (victim_c)
   );

   // Tag compare for both ports and way selection
   always_comb begin
      pmatch    = '0;
      umatch    = '0;
      ptarget_c = '0;
      uway      = '0;
      vway      = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         pmatch[w] = tbl[pidx][w].valid && (tbl[pidx][w].tag == ptag);
         umatch[w] = tbl[uidx][w].valid && (tbl[uidx][w].tag == utag);
         if (pmatch[w])   ptarget_c = tbl[pidx][w].target;
         if (umatch[w])   uway      = WAY_W'(w);
         if (victim_c[w]) vway      = WAY_W'(w);
      end
      hit_c = predict_valid && $onehot(pmatch);
      uhit  = |umatch;
      wway  = uhit ? uway : vway;
   end

   // Update-port writes are issued last so they win over predict increments
   always_ff @(posedge clk) begin
      if (start) begin
         hit                    <= 1'b0;
         target_address_predict <= '0;
         age                    <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) begin
               tbl[s][w].valid <= 1'b0;
               tbl[s][w].cnt   <= '0;
            end
         end
      end else begin
         hit                    <= hit_c;
         target_address_predict <= hit_c ? ptarget_c : '0;
         age                    <= age_wrap ? '0 : age + AGE_W'(1);
         if (flush) begin
            for (int s = 0; s < int'(SETS); s++) begin
               for (int w = 0; w < int'(WAYS); w++) begin
                  tbl[s][w].valid <= 1'b0;
                  tbl[s][w].cnt   <= '0;
               end
            end
         end else begin
            for (int s = 0; s < int'(SETS); s++) begin
               for (int w = 0; w < int'(WAYS); w++) begin
                  if (age_wrap)
                     tbl[s][w].cnt <= tbl[s][w].cnt >> 1;
                  else if (hit_c && (pidx == IDX_W'(s)) && pmatch[w])
                     tbl[s][w].cnt <= sat_inc(tbl[s][w].cnt);
               end
            end
            if (update && update_taken) begin
               tbl[uidx][wway].target <= target_address_update;
               if (uhit) begin
                  if (!age_wrap) tbl[uidx][wway].cnt <= sat_inc(tbl[uidx][wway].cnt);
               end else begin
                  tbl[uidx][wway].valid <= 1'b1;
                  tbl[uidx][wway].tag   <= utag;
                  tbl[uidx][wway].cnt   <= CNT_W'(1);
               end
            end else if (update && uhit) begin
               tbl[uidx][wway].valid <= 1'b0;
               tbl[uidx][wway].cnt   <= '0;
            end
         end
      end
   end

   // Duplicate tags in a set can only come from a design bug
   always_ff @(posedge clk) begin
      if (!start && predict_valid) begin
         a_single_match: assert ($countones(pmatch) <= 1);
      end
   end
endmodule

// File: tb/tb_btb_assoc_lfu.sv
// Directed bench for btb_assoc_lfu: vector table for lookup/update/flush ordering,
// hand sequences for LFU replacement, aging and reset-during-update.
module tb_btb_assoc_lfu;
   logic        clk = 1'b0;
   logic        start, predict_valid, update, update_taken, flush, hit;
   logic [31:0] PC_predict, PC_update, target_address_update, target_address_predict;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          age_m   = 0;

   always #5 clk = ~clk;

   btb_assoc_lfu dut (
      .clk                    (clk),
      .start                  (start),
      .predict_valid          (predict_valid),
      .PC_predict             (PC_predict),
      .hit                    (hit),
      .target_address_predict (target_address_predict),
      .update                 (update),
      .update_taken           (update_taken),
      .PC_update              (PC_update),
      .target_address_update  (target_address_update),
      .flush                  (flush)
   );

   // Reference age counter: halving happens on the edge where this reads 4095 beforehand
   always @(posedge clk) begin
      if (start) age_m <= 0;
      else       age_m <= (age_m == 4095) ? 0 : age_m + 1;
   end

   typedef struct {
      logic        pv;
      logic [31:0] ppc;
      logic        upd;
      logic        tk;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        fl;
      logic        ehit;
      logic [31:0] etgt;
   } vec_t;

   vec_t vt [17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      start = 1'b0; predict_valid = 1'b0; update = 1'b0; update_taken = 1'b0; flush = 1'b0;
      PC_predict = '0; PC_update = '0; target_address_update = '0;
   endtask

   task automatic check(input string nm, input logic eh, input logic [31:0] et);
      n_tests++;
      if (hit !== eh || target_address_predict !== et) begin
         n_fail++;
         $display("FAIL %s: got hit=%0b target=%h, expected hit=%0b target=%h",
                  nm, hit, target_address_predict, eh, et);
      end
   endtask

   task automatic do_reset();
      idle();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic install(input logic [31:0] pc, input logic [31:0] tgt);
      update = 1'b1; update_taken = 1'b1; PC_update = pc; target_address_update = tgt;
      step();
      update = 1'b0; update_taken = 1'b0;
   endtask

   task automatic invalidate(input logic [31:0] pc);
      update = 1'b1; update_taken = 1'b0; PC_update = pc;
      step();
      update = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic eh, input logic [31:0] et, input string nm);
      predict_valid = 1'b1; PC_predict = pc;
      step();
      predict_valid = 1'b0;
      check(nm, eh, et);
   endtask

   task automatic predict_n(input logic [31:0] pc, input int n);
      predict_valid = 1'b1; PC_predict = pc;
      repeat (n) step();
      predict_valid = 1'b0;
   endtask

   initial begin
      //        pv    ppc           upd   tk    upc        utgt        fl    ehit  etgt
      vt[0]  = '{1'b1, 32'h100,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};
      vt[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 32'h2000, 1'b0, 1'b0, 32'h0};
      vt[2]  = '{1'b1, 32'h100,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, 32'h2000};
      vt[3]  = '{1'b1, 32'h100,       1'b1, 1'b1, 32'h100, 32'h2400, 1'b0, 1'b1, 32'h2000};
      vt[4]  = '{1'b1, 32'h100,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, 32'h2400};
      vt[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h100, 32'h0,    1'b0, 1'b0, 32'h0};
      vt[6]  = '{1'b1, 32'h100,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};
      vt[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h500, 32'h0,    1'b0, 1'b0, 32'h0};
      vt[8]  = '{1'b1, 32'h300,       1'b1, 1'b1, 32'h300, 32'h3000, 1'b0, 1'b0, 32'h0};
      vt[9]  = '{1'b1, 32'h300,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, 32'h3000};
      vt[10] = '{1'b0, 32'h300,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};
      vt[11] = '{1'b1, 32'h304,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};
      vt[12] = '{1'b1, 32'h8000_0303, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, 32'h3000};
      vt[13] = '{1'b1, 32'h300,       1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 32'h3000};
      vt[14] = '{1'b1, 32'h300,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};
      vt[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h300, 32'h3300, 1'b1, 1'b0, 32'h0};
      vt[16] = '{1'b1, 32'h300,       1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 32'h0};

      do_reset();
      check("reset_outputs", 1'b0, 32'h0);

      // Vector table: lookup/update ordering, invalidate, flush
      for (int i = 0; i < 17; i++) begin
         predict_valid = vt[i].pv;  PC_predict = vt[i].ppc;
         update = vt[i].upd;        update_taken = vt[i].tk;
         PC_update = vt[i].upc;     target_address_update = vt[i].utgt;
         flush = vt[i].fl;
         step();
         idle();
         check($sformatf("vec%0d", i), vt[i].ehit, vt[i].etgt);
      end

      // LFU replacement: cnts 5,3,1,3 -> way holding 0x100 evicted
      do_reset();
      install(32'h000, 32'hA000); install(32'h080, 32'hA080);
      install(32'h100, 32'hA100); install(32'h180, 32'hA180);
      predict_n(32'h000, 4); predict_n(32'h080, 2); predict_n(32'h180, 2);
      install(32'h200, 32'hA200);
      lookup(32'h100, 1'b0, 32'h0,     "lfu_evicted");
      lookup(32'h200, 1'b1, 32'hA200,  "lfu_new");
      lookup(32'h000, 1'b1, 32'hA000,  "lfu_keep0");
      lookup(32'h080, 1'b1, 32'hA080,  "lfu_keep1");
      lookup(32'h180, 1'b1, 32'hA180,  "lfu_keep3");
      // invalid way preferred over lower-count valid way
      invalidate(32'h080);
      install(32'h280, 32'hA280);
      lookup(32'h200, 1'b1, 32'hA200,  "inv_first_keep");
      lookup(32'h280, 1'b1, 32'hA280,  "inv_first_new");

      // Tie: all cnt=1 -> way 0 evicted
      do_reset();
      install(32'h000, 32'hB000); install(32'h080, 32'hB080);
      install(32'h100, 32'hB100); install(32'h180, 32'hB180);
      install(32'h200, 32'hB200);
      lookup(32'h000, 1'b0, 32'h0,     "tie_evicted");
      lookup(32'h080, 1'b1, 32'hB080,  "tie_keep1");
      lookup(32'h200, 1'b1, 32'hB200,  "tie_new");

      // Aging: all ways at 0xFF, halve to 0x7F; predict on wrap dropped
      do_reset();
      install(32'h000, 32'hC000); install(32'h080, 32'hC080);
      install(32'h100, 32'hC100); install(32'h180, 32'hC180);
      predict_n(32'h000, 254); predict_n(32'h080, 254);
      predict_n(32'h100, 254); predict_n(32'h180, 254);
      for (int g = 0; g < 5000 && age_m != 4095; g++) step();
      n_tests++;
      if (age_m != 4095) begin
         n_fail++;
         $display("FAIL age_wait: reference age=%0d, expected 4095 within bound", age_m);
      end
      lookup(32'h180, 1'b1, 32'hC180,  "wrap_predict");
      lookup(32'h000, 1'b1, 32'hC000,  "post_wrap0");
      lookup(32'h080, 1'b1, 32'hC080,  "post_wrap1");
      lookup(32'h100, 1'b1, 32'hC100,  "post_wrap2");
      install(32'h200, 32'hC200);
      lookup(32'h180, 1'b0, 32'h0,     "aged_evicted");
      lookup(32'h200, 1'b1, 32'hC200,  "aged_new");
      lookup(32'h000, 1'b1, 32'hC000,  "aged_keep0");

      // start during an update: table empty, install discarded
      update = 1'b1; update_taken = 1'b1; PC_update = 32'h380; target_address_update = 32'hD380;
      predict_valid = 1'b1; PC_predict = 32'h000;
      start = 1'b1;
      step();
      idle();
      check("start_outputs", 1'b0, 32'h0);
      lookup(32'h380, 1'b0, 32'h0,     "start_drop_update");
      lookup(32'h000, 1'b0, 32'h0,     "start_clears");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
